// File: rtl/pipe_pkg.sv
// Shared pipeline widths and the field layout of the decode/execute boundary.
// The layout is used wherever an ID/EX control word or payload is packed or unpacked.
package pipe_pkg;

    localparam int WB_W       = 2;
    localparam int M_W        = 3;
    localparam int EX_W       = 4;
    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 32;

    localparam int ID_EX_CTRL_W = WB_W + M_W + EX_W;
    localparam int ID_EX_DATA_W = 3 * REG_ADDR_W + 4 * WORD_W;

    // Control word, LSB first: EX, M, WB.
    localparam int CTRL_EX_LSB = 0;
    localparam int CTRL_M_LSB  = CTRL_EX_LSB + EX_W;
    localparam int CTRL_WB_LSB = CTRL_M_LSB + M_W;

    // Payload, LSB first: imm, data2, data1, pc+4, rd, rt, rs.
    localparam int DATA_IMM_LSB   = 0;
    localparam int DATA_DATA2_LSB = DATA_IMM_LSB + WORD_W;
    localparam int DATA_DATA1_LSB = DATA_DATA2_LSB + WORD_W;
    localparam int DATA_PC4_LSB   = DATA_DATA1_LSB + WORD_W;
    localparam int DATA_RD_LSB    = DATA_PC4_LSB + WORD_W;
    localparam int DATA_RT_LSB    = DATA_RD_LSB + REG_ADDR_W;
    localparam int DATA_RS_LSB    = DATA_RT_LSB + REG_ADDR_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

    function automatic logic [ID_EX_CTRL_W-1:0] pack_id_ex_ctrl(
        input logic [WB_W-1:0] wb,
        input logic [M_W-1:0]  m,
        input logic [EX_W-1:0] ex
    );
        return {wb, m, ex};
    endfunction

    function automatic logic [ID_EX_DATA_W-1:0] pack_id_ex_data(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rt,
        input logic [REG_ADDR_W-1:0] rd,
        input logic [WORD_W-1:0]     pc4,
        input logic [WORD_W-1:0]     data1,
        input logic [WORD_W-1:0]     data2,
        input logic [WORD_W-1:0]     imm
    );
        return {rs, rt, rd, pc4, data1, data2, imm};
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One pipeline slot: valid flag, control word and payload with load/clear.
// Clear drops the instruction and zeroes control but keeps the payload bits.
module pipe_entry #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 143
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] load_ctrl,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic              valid_reg;
    logic [CTRL_W-1:0] ctrl_reg;
    logic [DATA_W-1:0] data_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_reg <= 1'b0;
            ctrl_reg  <= '0;
            data_reg  <= '0;
        end else if (clear) begin
            valid_reg <= 1'b0;
            ctrl_reg  <= '0;
        end else if (load) begin
            valid_reg <= 1'b1;
            ctrl_reg  <= load_ctrl;
            data_reg  <= load_data;
        end
    end

    assign valid = valid_reg;
    assign ctrl  = ctrl_reg;
    assign data  = data_reg;

endmodule

// File: rtl/id_ex_pipe_stage.sv
// Valid/ready interstage register with flush-to-bubble and an optional skid slot
// so that in_ready can come straight from a flop.
module id_ex_pipe_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W = ID_EX_CTRL_W,
    parameter int DATA_W = ID_EX_DATA_W,
    parameter bit SKID   = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    stage_state_t state_reg, state_next;
    logic         ready_reg;

    logic              accept, consume;
    logic              main_load, main_clear, main_from_skid;
    logic              skid_load, skid_clear;
    logic              main_valid, skid_valid;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_next;
    logic [DATA_W-1:0] main_data, skid_data, main_data_next;

    assign accept  = in_valid & in_ready;
    assign consume = main_valid & out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= ST_EMPTY;
            ready_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next != ST_FULL);
        end
    end

    // Flush wins over everything, including an accept in the same cycle.
    always_comb begin
        state_next     = state_reg;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            state_next = ST_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (accept) begin
                        main_load  = 1'b1;
                        state_next = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        main_load = 1'b1;
                    end else if (accept && SKID) begin
                        skid_load  = 1'b1;
                        state_next = ST_FULL;
                    end else if (consume) begin
                        main_clear = 1'b1;
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so the skid entry drains before newer input.
                    if (consume) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_next     = ST_ONE;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    assign main_ctrl_next = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_data_next = main_from_skid ? skid_data : in_data;

    pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .clock     (clock),
        .reset     (reset),
        .load      (main_load),
        .clear     (main_clear),
        .load_ctrl (main_ctrl_next),
        .load_data (main_data_next),
        .valid     (main_valid),
        .ctrl      (main_ctrl),
        .data      (main_data)
    );

    generate
        if (SKID) begin : g_skid
            pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .clock     (clock),
                .reset     (reset),
                .load      (skid_load),
                .clear     (skid_clear),
                .load_ctrl (in_ctrl),
                .load_data (in_data),
                .valid     (skid_valid),
                .ctrl      (skid_ctrl),
                .data      (skid_data)
            );
            // Gating with reset keeps in_ready low while reset is held.
            assign in_ready = ready_reg & ~reset;
        end else begin : g_noskid
            assign skid_valid = 1'b0;
            assign skid_ctrl  = '0;
            assign skid_data  = '0;
            assign in_ready   = (~main_valid | out_ready) & ~reset;
        end
    endgenerate

    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: doc/id_ex_pipe_stage.md
# id_ex_pipe_stage

Parametrised interstage register that replaces the fixed decode/execute latch with a valid/ready-handshaked stage. It carries a control field and a data payload from the producing stage to the consuming stage. It supports back-pressure (stall), flush-to-bubble, and an optional skid entry that keeps the upstream ready path registered. It sits between decode and execute and can be instantiated at any other interstage boundary.

## Interface
- CTRL_W, 9: width of control field (WB+M+EX); zeroed on bubble/flush
- DATA_W, 143: payload width (rs, rt, rd, PC+4, data1, data2, immediate)
- SKID, 1: 1 = two-entry stage with registered in_ready; 0 = single entry, in_ready combinational
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  discard all held entries this cycle
- in_valid  in  1  upstream offers in_ctrl/in_data
- in_ready  out  1  stage can accept
- in_ctrl  in  CTRL_W  control bits
- in_data  in  DATA_W  payload
- out_valid  out  1  out_ctrl/out_data hold a live instruction
- out_ready  in  1  downstream consumes (0 = stall)
- out_ctrl  out  CTRL_W  control; forced 0 whenever out_valid=0
- out_data  out  DATA_W  payload; holds last value when out_valid=0
- occupancy  out  2  entries held (0..2; max 1 when SKID=0)

## Operation
- Transfer in: in_valid & in_ready at rising edge. Transfer out: out_valid & out_ready.
- Entries: MAIN drives outputs; SKID (SKID=1 only) holds one overflow instruction.
- States (SKID=1): EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid).
  - EMPTY: accept -> ONE.
  - ONE: accept & no consume -> FULL (input to skid); accept & consume -> ONE (input to main); consume only -> EMPTY.
  - FULL: consume -> ONE (skid moves to main); in_ready=0, so no accept.
- in_ready: SKID=1: !FULL, registered. SKID=0: !out_valid | out_ready.
- flush: next state EMPTY, occupancy 0, out_ctrl 0. It has priority over a simultaneous accept, and any instruction offered that cycle is dropped. Flush ignores out_ready. A transfer out in the same cycle still counts as consumed downstream.
- Order preserved: the skid entry always drains before any newer input.
- out_data is not cleared on bubble, only out_ctrl. That is enough to make the bubble a NOP.

## Timing
- Reset (asynchronous assert, synchronous-safe release): out_valid=0, out_ctrl=0, out_data=0, occupancy=0, state EMPTY. in_ready=0 while reset is high, and 1 on the first cycle after release.
- Latency: accepted input appears on outputs one cycle later (next edge), in both modes.
- Throughput: 1 per cycle when out_ready=1 continuously.
- Stall: out_ready=0 holds out_ctrl/out_data stable until consumed.
- SKID=1 accepts exactly one more instruction after out_ready falls, then deasserts in_ready the next cycle.
- in_ready is a function of registers only when SKID=1. No combinational path from out_ready to in_ready.
- Reset mid-operation: all entries lost immediately, no partial transfer.

## Structure
- Shared package pipe_pkg: WB_W=2, M_W=3, EX_W=4, REG_ADDR_W=5, WORD_W=32. It also holds derived ID_EX_CTRL_W and ID_EX_DATA_W and the field offset constants used to pack/unpack the payload.
- Packing and unpacking of named fields happens at the instantiation site, not inside this block.
- One sub-module, pipe_entry: a valid + ctrl + data register with load/clear, instantiated as MAIN and SKID.

## Test plan
- Reset release, in_valid=1, in_ctrl=9'h1A5, in_data=143'h5 -> next edge out_valid=1, out_ctrl=9'h1A5, out_data=5, occupancy=1.
- Stream of 8 values 1..8, out_ready=1 -> outputs 1..8 on consecutive cycles, in_ready constantly 1.
- SKID=1, out_ready=0 while streaming 1,2,3 -> 1 at output, 2 in skid, in_ready=0, occupancy=2, 3 held upstream. Then out_ready=1 -> outputs 1,2,3 in order, no loss or duplication.
- Flush while FULL with simultaneous in_valid (value 9) -> next cycle out_valid=0, out_ctrl=0, occupancy=0. Value 9 is dropped and in_ready=1.
- SKID=0, out_ready=0 -> in_ready=0 the same cycle. out_ready=1 with in_valid -> pass-through replacement each cycle.
- Assert reset while FULL mid-stream -> outputs zero immediately (asynchronous, before the next edge). After release, the first accepted value appears with 1-cycle latency.
